// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: opcodes, access encodings, FSM states.
// Define LSU_MISALIGN_TRAP_EN to make misaligned half/word accesses fault.
package lsu_pkg;

  localparam logic [6:0] OPC_LOAD  = 7'b0000011;
  localparam logic [6:0] OPC_STORE = 7'b0100011;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

`ifdef LSU_MISALIGN_TRAP_EN
  localparam bit MISALIGN_TRAP = 1'b1;
`else
  localparam bit MISALIGN_TRAP = 1'b0;
`endif

  typedef enum logic [2:0] {IDLE, RD, RDWAIT, WR, RESP} state_e;

  typedef enum logic [1:0] {ACC_FAULT, ACC_LOAD, ACC_STORE_SUB, ACC_STORE_WORD} acc_e;

  // Decides which path an incoming request takes through the FSM.
  function automatic acc_e classify(input logic [6:0] opcode, input logic [2:0] funct3,
                                    input logic [1:0] offset);
    acc_e acc;
    logic misaligned;
    acc = ACC_FAULT;
    misaligned = MISALIGN_TRAP &&
                 (((funct3 == F3_H || funct3 == F3_HU) && offset[0]) ||
                  (funct3 == F3_W && offset != 2'b00));
    if (opcode == OPC_LOAD) begin
      if (funct3 == F3_B || funct3 == F3_H || funct3 == F3_W ||
          funct3 == F3_BU || funct3 == F3_HU)
        acc = ACC_LOAD;
    end else if (opcode == OPC_STORE) begin
      if (funct3 == F3_B || funct3 == F3_H) acc = ACC_STORE_SUB;
      else if (funct3 == F3_W)               acc = ACC_STORE_WORD;
    end
    if (misaligned) acc = ACC_FAULT;
    return acc;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering: load extraction/extension and read-modify-write store merging.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  offset,
  input  logic [31:0] word,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] store_data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Halfword lanes use only offset[1]; the low bit is either ignored or already trapped.
  always_comb begin
    // NOTE: every output gets a default first so no path through the case infers a latch.
    byte_sel   = word[{offset, 3'b000} +: 8];
    half_sel   = offset[1] ? word[31:16] : word[15:0];
    load_data  = '0;
    store_data = wdata;
    case (funct3)
      F3_B:  load_data = {{24{byte_sel[7]}}, byte_sel};
      F3_H:  load_data = {{16{half_sel[15]}}, half_sel};
      F3_W:  load_data = word;
      F3_BU: load_data = {24'd0, byte_sel};
      F3_HU: load_data = {16'd0, half_sel};
      default: load_data = '0;
    endcase
    if (funct3 == F3_B) begin
      store_data = word;
      store_data[{offset, 3'b000} +: 8] = wdata[7:0];
    end else if (funct3 == F3_H) begin
      store_data = word;
      if (offset[1]) store_data[31:16] = wdata[15:0];
      else           store_data[15:0]  = wdata[15:0];
    end
  end

endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding load/store unit against a one-cycle-latency word memory.
// Misalignment trapping is enabled with the LSU_MISALIGN_TRAP_EN macro.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int WADDR_W = 9
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [6:0]         req_opcode,
  input  logic [2:0]         req_funct3,
  input  logic [ADDR_W-1:0]  req_addr,
  input  logic [31:0]        req_wdata,
  output logic               resp_valid,
  input  logic               resp_ready,
  output logic [31:0]        resp_rdata,
  output logic               resp_fault,
  output logic [WADDR_W-1:0] mem_addr,
  output logic               mem_rd,
  output logic               mem_wr,
  output logic [31:0]        mem_wdata,
  input  logic [31:0]        mem_rdata
);

  state_e           state, state_nx;
  acc_e             req_acc;
  logic [6:0]       opcode_q;
  logic [2:0]       funct3_q;
  logic [WADDR_W+1:0] addr_q;
  logic [31:0]      wdata_q;
  logic [31:0]      load_data, store_data;
  logic             is_load;
  logic             unused_addr_hi;

  assign req_acc        = classify(req_opcode, req_funct3, req_addr[1:0]);
  assign is_load        = (opcode_q == OPC_LOAD);
  assign mem_addr       = addr_q[WADDR_W+1:2];
  assign unused_addr_hi = ^req_addr[ADDR_W-1:WADDR_W+2];

  lsu_align u_align (
    .funct3     (funct3_q),
    .offset     (addr_q[1:0]),
    .word       (mem_rdata),
    .wdata      (wdata_q),
    .load_data  (load_data),
    .store_data (store_data)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx   = state;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    mem_rd     = 1'b0;
    mem_wr     = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          case (req_acc)
            ACC_LOAD, ACC_STORE_SUB: state_nx = RD;
            ACC_STORE_WORD:          state_nx = WR;
            default:                 state_nx = RESP;
          endcase
        end
      end
      RD: begin
        mem_rd   = 1'b1;
        state_nx = RDWAIT;
      end
      RDWAIT: state_nx = is_load ? RESP : WR;
      WR: begin
        mem_wr   = 1'b1;
        state_nx = RESP;
      end
      RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Request capture, load result and store word; all held stable while in RESP.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses <= only, so every reader this edge sees pre-edge values.
    if (rst) begin
      opcode_q   <= '0;
      funct3_q   <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      resp_rdata <= '0;
      resp_fault <= 1'b0;
      mem_wdata  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            opcode_q   <= req_opcode;
            funct3_q   <= req_funct3;
            addr_q     <= req_addr[WADDR_W+1:0];
            wdata_q    <= req_wdata;
            resp_rdata <= '0;
            resp_fault <= (req_acc == ACC_FAULT);
            if (req_acc == ACC_STORE_WORD) mem_wdata <= req_wdata;
          end
        end
        RDWAIT: begin
          if (is_load) resp_rdata <= load_data;
          else         mem_wdata  <= store_data;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: directed loads, stores, faults, backpressure, reset abort.
`timescale 1ns/1ps
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready;
  logic [6:0]  req_opcode;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_ready, resp_fault;
  logic [31:0] resp_rdata;
  logic [8:0]  mem_addr;
  logic        mem_rd, mem_wr;
  logic [31:0] mem_wdata, mem_rdata;

  always #5 clk = ~clk;

  load_store_unit #(.ADDR_W(32), .WADDR_W(9)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_opcode(req_opcode),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
    .resp_fault(resp_fault), .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  localparam logic [6:0] LD = 7'b0000011;
  localparam logic [6:0] ST = 7'b0100011;

  typedef struct { logic [31:0] rdata; logic fault; int lat; int acc_cyc; } exp_t;
  typedef struct { logic [8:0] addr; logic [31:0] data; } wr_t;

  exp_t        exp_q[$];
  wr_t         wr_q[$];
  exp_t        cur;
  logic [31:0] mem [512];
  int          n_cmp = 0, n_err = 0;
  int          cyc = 0, rd_cnt = 0, wr_cnt = 0, overlap = 0;
  bit          active = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, expv);
    end
  endtask

  // Memory model: registered read, data valid the cycle after mem_rd.
  always @(posedge clk) begin
    cyc++;
    if (mem_rd) mem_rdata <= mem[mem_addr];
    if (mem_wr) mem[mem_addr] <= mem_wdata;
  end

  // Memory-side monitor: strobe counts and expected writes.
  always @(negedge clk) begin
    if (mem_rd) rd_cnt++;
    if (mem_wr) wr_cnt++;
    if (mem_rd && mem_wr) overlap++;
    if (mem_wr) begin
      if (wr_q.size() == 0) begin
        n_cmp++; n_err++;
        $display("FAIL unexpected_write: addr 0x%03h data 0x%08h", mem_addr, mem_wdata);
      end else begin
        wr_t w;
        w = wr_q.pop_front();
        check("write_addr", 32'(mem_addr), 32'(w.addr));
        check("write_data", mem_wdata, w.data);
      end
    end
  end

  // Response monitor: pops on a new response, then checks it stays put until consumed.
  always @(negedge clk) begin
    if (rst) active = 1'b0;
    else if (!active && resp_valid) begin
      if (exp_q.size() == 0) begin
        n_cmp++; n_err++;
        $display("FAIL unexpected_resp: rdata 0x%08h fault %0d", resp_rdata, resp_fault);
      end else begin
        cur = exp_q.pop_front();
        check("resp_latency", 32'(cyc - cur.acc_cyc), 32'(cur.lat));
        check("resp_rdata", resp_rdata, cur.rdata);
        check("resp_fault", 32'(resp_fault), 32'(cur.fault));
        active = 1'b1;
      end
    end else if (active) begin
      check("hold_valid", 32'(resp_valid), 32'd1);
      check("hold_rdata", resp_rdata, cur.rdata);
      check("hold_fault", 32'(resp_fault), 32'(cur.fault));
    end
    if (active && resp_valid && resp_ready) active = 1'b0;
  end

  task automatic issue(input logic [6:0] opc, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [31:0] exp_rdata,
                       input logic exp_fault, input int exp_lat, input bit push_resp);
    bit acc;
    acc = 1'b0;
    @(posedge clk); #1;
    req_valid = 1'b1; req_opcode = opc; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (req_ready) begin acc = 1'b1; break; end
    end
    if (!acc) begin
      n_cmp++; n_err++;
      $display("FAIL req_accept_timeout: addr 0x%08h", addr);
    end else if (push_resp) begin
      exp_q.push_back('{rdata: exp_rdata, fault: exp_fault, lat: exp_lat, acc_cyc: cyc});
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic drain();
    bit done;
    done = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk); #2;
      if (exp_q.size() == 0 && !active) begin done = 1'b1; break; end
    end
    if (!done) begin
      n_cmp++; n_err++;
      $display("FAIL drain_timeout: %0d responses outstanding", exp_q.size());
    end
  endtask

  task automatic expect_write(input logic [8:0] a, input logic [31:0] d);
    wr_q.push_back('{addr: a, data: d});
  endtask

  initial begin
    int r0, w0;
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int r0, w0;
    rst = 1'b1; req_valid = 1'b0; req_opcode = '0; req_funct3 = '0;
    req_addr = '0; req_wdata = '0; resp_ready = 1'b1;
    for (int i = 0; i < 512; i++) mem[i] = 32'(i) * 32'h01010101;
    mem[5] = 32'h8899AABB;
    mem[8] = 32'hDEADBEEF;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_req_ready", 32'(req_ready), 32'd1);
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_resp_fault", 32'(resp_fault), 32'd0);
    check("rst_resp_rdata", resp_rdata, 32'd0);
    check("rst_mem_strobes", {30'd0, mem_rd, mem_wr}, 32'd0);
    check("rst_mem_addr", 32'(mem_addr), 32'd0);
    check("rst_mem_wdata", mem_wdata, 32'd0);
    @(posedge clk); #1 rst = 1'b0;

    // Loads from word 5 = 0x8899AABB.
    issue(LD, 3'b000, 32'h15, 0, 32'hFFFFFFAA, 0, 3, 1); drain();
    issue(LD, 3'b101, 32'h16, 0, 32'h00008899, 0, 3, 1); drain();
    issue(LD, 3'b010, 32'h14, 0, 32'h8899AABB, 0, 3, 1); drain();
    issue(LD, 3'b100, 32'h14, 0, 32'h000000BB, 0, 3, 1); drain();
    issue(LD, 3'b001, 32'h16, 0, 32'hFFFF8899, 0, 3, 1); drain();
    issue(LD, 3'b000, 32'h17, 0, 32'hFFFFFF88, 0, 3, 1); drain();
    issue(LD, 3'b001, 32'h14, 0, 32'hFFFFAABB, 0, 3, 1); drain();

    // SB into the top byte of word 5: one read, one merged write.
    r0 = rd_cnt; w0 = wr_cnt;
    expect_write(9'd5, 32'h1299AABB);
    issue(ST, 3'b000, 32'h17, 32'h00000012, 0, 0, 4, 1); drain();
    check("sb_rd_count", 32'(rd_cnt - r0), 32'd1);
    check("sb_wr_count", 32'(wr_cnt - w0), 32'd1);
    issue(LD, 3'b010, 32'h14, 0, 32'h1299AABB, 0, 3, 1); drain();

    // SW goes straight to WR with no read.
    r0 = rd_cnt; w0 = wr_cnt;
    expect_write(9'd8, 32'hCAFEF00D);
    issue(ST, 3'b010, 32'h20, 32'hCAFEF00D, 0, 0, 2, 1); drain();
    check("sw_rd_count", 32'(rd_cnt - r0), 32'd0);
    check("sw_wr_count", 32'(wr_cnt - w0), 32'd1);

    // SH into the upper half of word 8.
    expect_write(9'd8, 32'h5566F00D);
    issue(ST, 3'b001, 32'h22, 32'hFFFF5566, 0, 0, 4, 1); drain();
    issue(LD, 3'b101, 32'h22, 0, 32'h00005566, 0, 3, 1); drain();

    // Illegal encodings: fault next cycle, no memory strobes.
    r0 = rd_cnt; w0 = wr_cnt;
    issue(LD, 3'b011, 32'h14, 0, 32'h0, 1, 1, 1); drain();
    issue(ST, 3'b100, 32'h14, 32'h55, 32'h0, 1, 1, 1); drain();
    issue(7'b0110011, 3'b000, 32'h14, 0, 32'h0, 1, 1, 1); drain();
    check("fault_rd_count", 32'(rd_cnt - r0), 32'd0);
    check("fault_wr_count", 32'(wr_cnt - w0), 32'd0);

    // Misaligned word load and SH at byte offset 3.
`ifdef LSU_MISALIGN_TRAP_EN
    issue(LD, 3'b010, 32'h16, 0, 32'h0, 1, 1, 1); drain();
    issue(ST, 3'b001, 32'h23, 32'h7777, 0, 1, 1, 1); drain();
    issue(LD, 3'b010, 32'h20, 0, 32'h5566F00D, 0, 3, 1); drain();
`else
    issue(LD, 3'b010, 32'h16, 0, 32'h1299AABB, 0, 3, 1); drain();
    expect_write(9'd8, 32'h7777F00D);
    issue(ST, 3'b001, 32'h23, 32'h7777, 0, 0, 4, 1); drain();
    issue(LD, 3'b010, 32'h20, 0, 32'h7777F00D, 0, 3, 1); drain();
`endif

    // Backpressure: response must stay stable while resp_ready is low for 5 cycles.
    @(posedge clk); #1 resp_ready = 1'b0;
    issue(LD, 3'b000, 32'h14, 0, 32'hFFFFFFBB, 0, 3, 1);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (resp_valid) break;
    end
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("held_resp_valid", 32'(resp_valid), 32'd1);
    @(posedge clk); #1 resp_ready = 1'b1;
    drain();

    // Reset while an SH sits in RDWAIT: no write, back to IDLE at once.
    w0 = wr_cnt;
    issue(ST, 3'b001, 32'h14, 32'h0000AAAA, 0, 0, 0, 0);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check("abort_req_ready", 32'(req_ready), 32'd1);
    check("abort_resp_valid", 32'(resp_valid), 32'd0);
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("abort_wr_count", 32'(wr_cnt - w0), 32'd0);
    issue(LD, 3'b010, 32'h14, 0, 32'h1299AABB, 0, 3, 1); drain();

    check("strobe_overlap", 32'(overlap), 32'd0);
    check("writes_pending", 32'(wr_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, byte-address width of requests.
REQ-002 SHALL have parameter WADDR_W, default 9, word-address width toward data memory (512 words).
REQ-003 SHALL have one clock and one synchronous, active-high reset: clk  in  1  rising-edge clock; rst  in  1  synchronous active-high reset.
REQ-004 SHALL have these request ports: req_valid  in  1  request offered; req_ready  out  1  request accepted when both high; req_opcode  in  7  0000011 load, 0100011 store; req_funct3  in  3  access type; req_addr  in  ADDR_W  byte address; req_wdata  in  32  store data.
REQ-005 SHALL have these response ports: resp_valid  out  1  response present; resp_ready  in  1  response consumed; resp_rdata  out  32  extended load data; resp_fault  out  1  access rejected.
REQ-006 SHALL have these memory ports: mem_addr  out  WADDR_W  word index = req_addr[WADDR_W+1:2]; mem_rd  out  1; mem_wr  out  1; mem_wdata  out  32; mem_rdata  in  32, valid the cycle after mem_rd.

Function
REQ-007 SHALL implement FSM states IDLE, RD, RDWAIT, WR, RESP.
REQ-008 SHALL assert req_ready only in IDLE; acceptance SHALL register opcode, funct3, addr, wdata.
REQ-009 Accepted load or sub-word store SHALL go IDLE->RD->RDWAIT; a word store SHALL go IDLE->WR.
REQ-010 In RD SHALL assert mem_rd for exactly one cycle; in RDWAIT SHALL capture mem_rdata.
REQ-011 Load: RDWAIT->RESP; resp_valid SHALL rise 3 cycles after the accepting edge.
REQ-012 Load extraction by addr[1:0]: LB(000) sign-extend byte, LH(001) sign-extend half, LW(010) full word, LBU(100) zero-extend byte, LHU(101) zero-extend half.
REQ-013 Sub-word store: RDWAIT->WR; mem_wdata SHALL be the captured word with only the addressed byte (SB 000) or half (SH 001) replaced from req_wdata low bits.
REQ-014 SW(010): mem_wdata SHALL equal req_wdata; mem_wr asserted exactly one cycle in WR; WR->RESP.
REQ-015 Any other opcode/funct3 pair SHALL go IDLE->RESP with resp_fault=1, resp_rdata=0, and no mem_rd/mem_wr.
REQ-016 RESP SHALL hold resp_valid, resp_rdata, resp_fault stable until resp_ready=1, then return to IDLE; stores SHALL return resp_rdata=0.
REQ-017 mem_rd and mem_wr SHALL never be high in the same cycle; mem_addr SHALL be held constant from RD through WR.
REQ-018 Byte offset SHALL not wrap: SH at offset 3 is misaligned (see REQ-023).

Reset
REQ-019 rst high SHALL force IDLE next cycle, mid-operation included, abandoning any transaction without further mem_wr.
REQ-020 After reset: req_ready=1, resp_valid=0, resp_fault=0, resp_rdata=0, mem_rd=0, mem_wr=0, mem_addr=0, mem_wdata=0.

Configuration
REQ-021 Macro LSU_MISALIGN_TRAP_EN SHALL select misalignment handling.
REQ-022 Without it, halfword accesses SHALL ignore addr[0] and word accesses SHALL ignore addr[1:0].
REQ-023 With it, half with addr[0]=1 or word with addr[1:0]!=0 SHALL take the REQ-015 fault path.

Structure
REQ-024 Package lsu_pkg SHALL hold opcode constants, funct3 encodings, and the FSM state enum.
REQ-025 Combinational sub-module lsu_align SHALL perform load extraction/extension and store merging; the FSM stays in load_store_unit.

Verification
REQ-026 Memory word 5 = 0x8899AABB; LB addr 0x15 -> resp_rdata 0xFFFFFFAA, 3-cycle latency.
REQ-027 Same word; LHU addr 0x16 -> 0x00008899; LW addr 0x14 -> 0x8899AABB.
REQ-028 SB addr 0x17, wdata 0x12 -> one mem_rd then one mem_wr of 0x1299AABB to word 5.
REQ-029 funct3 011 load -> resp_fault=1 next cycle, no memory strobes; LW addr 0x16 faults only with LSU_MISALIGN_TRAP_EN.
REQ-030 rst in RDWAIT of an SH -> no mem_wr, IDLE with req_ready=1 next cycle; resp_ready held low 5 cycles -> response stable throughout.
